dot_product_accum: RTL

- Downstream consumer of the pipelined unsigned multiplier. It accumulates LEN consecutive products into one dot-product result and presents that result on a valid/ready output.
- It gates operand issue into the multiplier through in_ready.
- The multiplier pipeline has no valid or reset, so this block carries a matching DELAY-deep valid shift line to mark which product samples are real.

---
 rtl/dot_accum_pkg.sv | 29 ++
 rtl/valid_delay_line.sv | 35 +++
 rtl/dot_product_accum.sv | 131 +++++++++++++
 3 files changed

// File: rtl/dot_accum_pkg.sv
// -----------------------------------------------------------------------------
// dot_accum_pkg
// Shared constants for the dot-product accumulator and its upstream multiplier.
//   ST_ACCUM / ST_DONE : accumulator state encoding
//   WIDTH_A / WIDTH_B  : default multiplier operand widths
//   clog2()            : ceiling log2, used to size the term counters
// -----------------------------------------------------------------------------
package dot_accum_pkg;

  localparam logic [0:0] ST_ACCUM = 1'b0;
  localparam logic [0:0] ST_DONE  = 1'b1;

  localparam int WIDTH_A = 4;
  localparam int WIDTH_B = 6;

  // Ceiling log2; a value of 1 still needs one bit of storage.
  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = n - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/valid_delay_line.sv
// -----------------------------------------------------------------------------
// valid_delay_line
// Reset-clearable 1-bit shift register that shadows an un-reset datapath pipe,
// marking which samples leaving that pipe are real.
//   clk : rising-edge clock
//   rst : synchronous, active-high reset; clears every stage
//   d   : bit entering stage 0
//   q   : all DELAY taps; q[DELAY-1] is d delayed by DELAY cycles
// -----------------------------------------------------------------------------
module valid_delay_line #(
  parameter int DELAY = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             d,
  output logic [DELAY-1:0] q
);

  generate
    if (DELAY == 1) begin : g_single
      always_ff @(posedge clk) begin
        // NOTE: this shift line is reset even though the datapath it shadows is
        // not; clearing it is what discards stale in-flight samples after reset.
        if (rst) q <= '0;
        else     q <= d;
      end
    end else begin : g_multi
      always_ff @(posedge clk) begin
        if (rst) q <= '0;
        else     q <= {q[DELAY-2:0], d};
      end
    end
  endgenerate

endmodule

// File: rtl/dot_product_accum.sv
// -----------------------------------------------------------------------------
// dot_product_accum
// Accumulates LEN consecutive products from a pipelined multiplier into one
// dot-product result, gating operand issue and presenting the result on a
// valid/ready output.
//   clk       : rising-edge clock, shared with the multiplier
//   rst       : synchronous, active-high reset
//   in_valid  : operand pair at the multiplier inputs is meaningful
//   in_ready  : an operand pair is accepted this cycle (issue = in_valid & in_ready)
//   prod      : multiplier output, DELAY cycles behind its operands
//   out_data  : dot-product result
//   out_valid : out_data holds a completed result
//   out_ready : consumer accepts the result
//   sat       : (DOT_ACCUM_SATURATE_EN only) a clamp occurred in this result
//   busy      : an issued product has not yet been accumulated
// Build option: define DOT_ACCUM_SATURATE_EN to clamp the accumulator at
// all-ones instead of wrapping, and to add the sat output.
// -----------------------------------------------------------------------------
module dot_product_accum
  import dot_accum_pkg::*;
#(
  parameter int WIDTH_P   = WIDTH_A + WIDTH_B,
  parameter int DELAY     = 5,
  parameter int LEN       = 8,
  parameter int ACC_WIDTH = WIDTH_P + clog2(LEN)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH_P-1:0]   prod,
  output logic [ACC_WIDTH-1:0] out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
`ifdef DOT_ACCUM_SATURATE_EN
  output logic                 sat,
`endif
  output logic                 busy
);

  localparam int CW = clog2(LEN + 1);
  localparam logic [CW-1:0] LEN_C  = CW'(LEN);
  localparam logic [CW-1:0] LAST_C = CW'(LEN - 1);

  logic [0:0]           state;
  logic [CW-1:0]        icnt;     // terms issued into the multiplier
  logic [CW-1:0]        rcnt;     // terms accumulated
  logic [ACC_WIDTH-1:0] acc;
  logic [ACC_WIDTH-1:0] acc_sum;
  logic [DELAY-1:0]     vld_pipe;
  logic                 issue;
  logic                 arrive;
  logic                 handshake;

  assign in_ready  = (state == ST_ACCUM) && (icnt < LEN_C);
  assign issue     = in_valid & in_ready;
  assign arrive    = vld_pipe[DELAY-1];
  assign handshake = out_valid & out_ready;
  assign busy      = (icnt != rcnt) | (|vld_pipe);

  // Tracks the multiplier pipeline so arrive lines up with the matching prod.
  valid_delay_line #(.DELAY(DELAY)) u_vld (
    .clk (clk),
    .rst (rst),
    .d   (issue),
    .q   (vld_pipe)
  );

`ifdef DOT_ACCUM_SATURATE_EN
  logic [ACC_WIDTH:0] sum_wide;
  logic               clamp;
  logic               sat_seen;   // a clamp has happened earlier in this vector

  always_comb begin
    // NOTE: every signal driven here gets a value on every path, so no latch
    // can be inferred.
    sum_wide = {1'b0, acc} + (ACC_WIDTH + 1)'(prod);
    clamp    = sum_wide[ACC_WIDTH];
    acc_sum  = clamp ? '1 : sum_wide[ACC_WIDTH-1:0];
  end
`else
  assign acc_sum = acc + ACC_WIDTH'(prod);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_ACCUM;
      icnt      <= '0;
      rcnt      <= '0;
      acc       <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
`ifdef DOT_ACCUM_SATURATE_EN
      sat       <= 1'b0;
      sat_seen  <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking assignments throughout, so every register here sees
      // the pre-edge value of every other register.
      if (issue) icnt <= icnt + 1'b1;

      if (state == ST_ACCUM) begin
        if (arrive) begin
          rcnt <= rcnt + 1'b1;
          if (rcnt == LAST_C) begin
            out_data  <= acc_sum;
            out_valid <= 1'b1;
            acc       <= '0;
            state     <= ST_DONE;
`ifdef DOT_ACCUM_SATURATE_EN
            sat       <= sat_seen | clamp;
            sat_seen  <= 1'b0;
`endif
          end else begin
            acc <= acc_sum;
`ifdef DOT_ACCUM_SATURATE_EN
            sat_seen <= sat_seen | clamp;
`endif
          end
        end
      end else if (handshake) begin
        // in_ready is low throughout DONE, so no arrival can collide with this.
        out_valid <= 1'b0;
        icnt      <= '0;
        rcnt      <= '0;
        state     <= ST_ACCUM;
      end
    end
  end

endmodule
